// File: rtl/b2p_stochastic_gen_if.sv
// b2p_stochastic_gen_if: input/output bundle for the binary-to-stochastic converter
//   master: drives enable, load, b_input, Nc; observes p_output, p_valid, window_done, load_ready
//   slave : the converter side of the same signals
interface b2p_stochastic_gen_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] b_input;
   logic [WIDTH-1:0] Nc;
   logic             p_output;
   logic             p_valid;
   logic             window_done;
   logic             load_ready;
   modport master (output enable, load, b_input, Nc, input p_output, p_valid, window_done, load_ready);
   modport slave  (input enable, load, b_input, Nc, output p_output, p_valid, window_done, load_ready);
endinterface

// File: rtl/b2p_stochastic_gen.sv
// b2p_stochastic_gen: binary-to-stochastic pulse converter, LFSR compare, windowed, double-buffered value
//   clk, rst          : clock, synchronous active-high reset
//   bus.enable        : advance generator this cycle
//   bus.load/b_input  : value capture request and data
//   bus.Nc            : window length in enabled cycles (0 = 2^WIDTH)
//   bus.p_output      : registered stochastic bit, qualified by bus.p_valid
//   bus.window_done   : pulses with the last bit of each window
//   bus.load_ready    : pending buffer empty
module b2p_stochastic_gen #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
   input logic                 clk,
   input logic                 rst,
   b2p_stochastic_gen_if.slave bus
);
   // an all-zero LFSR would lock up, so a zero seed is promoted to 1
   localparam logic [WIDTH-1:0] SEED_OK = (SEED == '0) ? WIDTH'(1) : SEED;
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] lfsr, lfsr_nxt, cnt, cnt_nxt, value_reg, value_nxt, pending, pending_nxt;
   logic             pend_full, pend_full_nxt, p_out, p_out_nxt, p_val, p_val_nxt, done, done_nxt;
   logic             step, last;
   always_comb begin
      state_nxt     = state;
      lfsr_nxt      = lfsr;
      cnt_nxt       = cnt;
      value_nxt     = value_reg;
      pending_nxt   = pending;
      pend_full_nxt = pend_full;
      p_out_nxt     = 1'b0;
      p_val_nxt     = 1'b0;
      done_nxt      = 1'b0;
      step          = (state == RUN) && bus.enable;
      // Nc-1 wraps, so Nc=0 gives a 2^WIDTH window
      last          = step && (cnt == bus.Nc - WIDTH'(1));
      if (state == IDLE) begin
         if (bus.load) begin
            value_nxt = bus.b_input;
            cnt_nxt   = '0;
            state_nxt = RUN;
         end
      end else begin
         if (step) begin
            p_out_nxt = lfsr < value_reg;
            p_val_nxt = 1'b1;
            lfsr_nxt  = {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
            cnt_nxt   = last ? '0 : cnt + WIDTH'(1);
            done_nxt  = last;
         end
         // window end promotes pending; a load arriving then refills it or bypasses it
         if (last && pend_full) begin
            value_nxt     = pending;
            pending_nxt   = bus.load ? bus.b_input : pending;
            pend_full_nxt = bus.load;
         end else if (last && bus.load) begin
            value_nxt = bus.b_input;
         end else if (bus.load && !pend_full) begin
            pending_nxt   = bus.b_input;
            pend_full_nxt = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= SEED_OK;
         cnt       <= '0;
         value_reg <= '0;
         pending   <= '0;
         pend_full <= 1'b0;
         p_out     <= 1'b0;
         p_val     <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         lfsr      <= lfsr_nxt;
         cnt       <= cnt_nxt;
         value_reg <= value_nxt;
         pending   <= pending_nxt;
         pend_full <= pend_full_nxt;
         p_out     <= p_out_nxt;
         p_val     <= p_val_nxt;
         done      <= done_nxt;
      end
   end
   assign bus.p_output    = p_out;
   assign bus.p_valid     = p_val;
   assign bus.window_done = done;
   assign bus.load_ready  = !pend_full;
endmodule

// File: tb/tb_b2p_stochastic_gen.sv
// tb_b2p_stochastic_gen: randomized self-checking bench against a behavioural stream model
module tb_b2p_stochastic_gen;
   localparam logic [15:0] SEED = 16'hACE1;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   b2p_stochastic_gen_if #(.WIDTH(16)) bus();
   b2p_stochastic_gen #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   // maximal-length Galois sequence x^16+x^14+x^13+x^11
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.load = 1'b0;
      bus.b_input = '0;
      bus.Nc = '0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic start(input logic [15:0] v, input logic [15:0] nc);
      bus.Nc = nc;
      bus.b_input = v;
      bus.load = 1'b1;
      tick;
      bus.load = 1'b0;
      bus.enable = 1'b1;
   endtask

   task automatic test_reset;
      int seen;
      rst = 1'b1;
      bus.load = 1'b1;
      bus.enable = 1'b1;
      bus.b_input = 16'($urandom);
      bus.Nc = 16;
      tick;
      tick;
      checks++; if (bus.p_output !== 1'b0) begin errors++; $display("FAIL reset_p_output: got %b expected 0", bus.p_output); end
      checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %b expected 0", bus.p_valid); end
      checks++; if (bus.window_done !== 1'b0) begin errors++; $display("FAIL reset_window_done: got %b expected 0", bus.window_done); end
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", bus.load_ready); end
      rst = 1'b0;
      bus.load = 1'b0;
      seen = 0;
      repeat (10) begin
         tick;
         if (bus.p_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL idle_no_valid: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_full_period;
      logic [15:0] m;
      int ones, bad, dones, done_at;
      do_reset;
      start(16'h8000, 16'hFFFF);
      m = SEED; ones = 0; bad = 0; dones = 0; done_at = -1;
      for (int i = 0; i < 65535; i++) begin
         tick;
         if (bus.p_valid !== 1'b1 || bus.p_output !== (m < 16'h8000)) bad++;
         ones += int'(bus.p_output);
         if (bus.window_done === 1'b1) begin dones++; done_at = i; end
         m = lfsr_next(m);
      end
      checks++; if (ones !== 32'h7FFF) begin errors++; $display("FAIL period_ones: got %0h expected 7fff", ones); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL period_bits: got %0d bad bits expected 0", bad); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL period_done_count: got %0d expected 1", dones); end
      checks++; if (done_at !== 65534) begin errors++; $display("FAIL period_done_pos: got %0d expected 65534", done_at); end
      tick;
      checks++; if (bus.window_done !== 1'b0 || bus.p_valid !== 1'b1) begin errors++; $display("FAIL next_window: got done=%b valid=%b expected done=0 valid=1", bus.window_done, bus.p_valid); end
   endtask

   task automatic test_values;
      logic [15:0] vals [3];
      logic [15:0] m;
      int ones, model, done_at;
      vals = '{16'h0000, 16'hFFFF, 16'h0001};
      foreach (vals[j]) begin
         do_reset;
         start(vals[j], 16'd1000);
         m = SEED; ones = 0; model = 0; done_at = -1;
         for (int i = 0; i < 1000; i++) begin
            tick;
            ones += int'(bus.p_output);
            model += int'(m < vals[j]);
            if (bus.window_done === 1'b1) done_at = i;
            m = lfsr_next(m);
         end
         // values 0 and 1 can never produce a one: the sequence never holds 0
         if (vals[j] != 16'hFFFF) model = 0;
         checks++; if (ones !== model) begin errors++; $display("FAIL value_%0h_ones: got %0d expected %0d", vals[j], ones, model); end
         checks++; if (done_at !== 999) begin errors++; $display("FAIL value_%0h_done: got %0d expected 999", vals[j], done_at); end
      end
   endtask

   task automatic test_handshake;
      logic [15:0] v0, a, b, c, d, e, m;
      logic [15:0] win_val [5];
      logic exp_r;
      int bad, bad_done;
      do_reset;
      v0 = 16'($urandom); a = 16'h4000; b = ~a; c = 16'($urandom); d = 16'($urandom); e = 16'($urandom);
      win_val = '{v0, a, c, d, e};
      start(v0, 16'd16);
      m = SEED; bad = 0; bad_done = 0;
      for (int k = 0; k < 80; k++) begin
         bus.load = (k == 3 || k == 5 || k == 31 || k == 40 || k == 47);
         bus.b_input = (k == 3) ? a : (k == 5) ? b : (k == 31) ? c : (k == 40) ? d : e;
         tick;
         bus.load = 1'b0;
         if (bus.p_output !== (m < win_val[k / 16])) bad++;
         if (bus.window_done !== (k % 16 == 15)) bad_done++;
         if (k == 3 || k == 5 || k == 15 || k == 31 || k == 40 || k == 47 || k == 63) begin
            exp_r = (k == 15 || k == 31 || k == 63);
            checks++; if (bus.load_ready !== exp_r) begin errors++; $display("FAIL ready_at_%0d: got %b expected %b", k, bus.load_ready, exp_r); end
         end
         m = lfsr_next(m);
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL handshake_bits: got %0d bad bits expected 0", bad); end
      checks++; if (bad_done !== 0) begin errors++; $display("FAIL handshake_done: got %0d bad pulses expected 0", bad_done); end
   endtask

   task automatic test_enable_toggle;
      logic [15:0] v, m;
      int bad, done_at, nvalid;
      do_reset;
      v = 16'($urandom);
      start(v, 16'd100);
      m = SEED; bad = 0; done_at = -1; nvalid = 0;
      for (int c = 0; c < 200; c++) begin
         bus.enable = (c % 2 == 0);
         tick;
         if (bus.enable) begin
            if (bus.p_valid !== 1'b1 || bus.p_output !== (m < v)) bad++;
            m = lfsr_next(m);
            nvalid++;
         end else if (bus.p_valid !== 1'b0 || bus.p_output !== 1'b0) bad++;
         if (bus.window_done === 1'b1) done_at = c;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_bits: got %0d bad cycles of %0d valid expected 0", bad, nvalid); end
      checks++; if (done_at !== 198) begin errors++; $display("FAIL toggle_done: got %0d expected 198", done_at); end
   endtask

   task automatic test_mid_reset;
      logic [15:0] v, m;
      logic ref_bits [40];
      int bad, bad2;
      do_reset;
      v = 16'($urandom);
      start(v, 16'd1000);
      m = SEED; bad = 0; bad2 = 0;
      for (int i = 0; i < 40; i++) begin
         bus.load = (i == 10);
         bus.b_input = ~v;
         tick;
         bus.load = 1'b0;
         ref_bits[i] = bus.p_output;
         if (bus.p_output !== (m < v)) bad++;
         m = lfsr_next(m);
      end
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_ready: got %b expected 0", bus.load_ready); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++; if (bus.p_valid !== 1'b0 || bus.load_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state: got valid=%b ready=%b expected valid=0 ready=1", bus.p_valid, bus.load_ready); end
      start(v, 16'd1000);
      for (int i = 0; i < 40; i++) begin
         tick;
         if (bus.p_output !== ref_bits[i]) bad2++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL pre_reset_bits: got %0d bad bits expected 0", bad); end
      checks++; if (bad2 !== 0) begin errors++; $display("FAIL replay_bits: got %0d differing bits expected 0", bad2); end
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.load = 1'b0;
      bus.b_input = '0;
      bus.Nc = '0;
      test_reset;
      test_full_period;
      test_values;
      test_handshake;
      test_enable_toggle;
      test_mid_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
